// File: rtl/alu_sequencer.sv
// Command sequencer for the 4-bit ALU: one op per handshake, two-cycle settle, writeback + flags.
// Optional ALU_SEQ_REPEAT_EN: cmd_rpt re-runs the op N extra times, chaining the result into A.
module alu_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_op,
    input  logic [1:0] cmd_dst,
    input  logic [1:0] cmd_srca,
    input  logic [1:0] cmd_srcb,
    input  logic       cmd_use_imm,
    input  logic [3:0] cmd_imm,
    input  logic [1:0] cmd_rpt,
    output logic [3:0] alu_op,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    input  logic [3:0] alu_c,
    input  logic       alu_zf,
    input  logic       alu_cf,
    output logic       done,
    output logic       zf,
    output logic       cf,
    input  logic [1:0] rd_sel,
    output logic [3:0] rd_data
);
    typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE} state_t;

    state_t     state, state_nxt;
    logic [3:0] regs [4];
    logic [1:0] dst;
    logic       accept, last;

    // cmd_ready is its own flop but tracks state==IDLE exactly
    assign accept  = cmd_valid && cmd_ready;
    assign rd_data = regs[rd_sel];

`ifdef ALU_SEQ_REPEAT_EN
    logic [1:0] rpt_cnt;
    assign last = (rpt_cnt == 2'd0);
`else
    logic unused_rpt;
    assign unused_rpt = ^cmd_rpt;
    assign last       = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = SETTLE;
            SETTLE:  state_nxt = CAPTURE;
            CAPTURE: state_nxt = last ? IDLE : SETTLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) regs[i] <= 4'h0;
            cmd_ready <= 1'b1;
            alu_op    <= 4'h0;
            alu_a     <= 4'h0;
            alu_b     <= 4'h0;
            dst       <= 2'd0;
            done      <= 1'b0;
            zf        <= 1'b0;
            cf        <= 1'b0;
`ifdef ALU_SEQ_REPEAT_EN
            rpt_cnt   <= 2'd0;
`endif
        end else begin
            done <= 1'b0;
            if (accept) begin
                alu_op    <= cmd_op;
                alu_a     <= regs[cmd_srca];
                alu_b     <= cmd_use_imm ? cmd_imm : regs[cmd_srcb];
                dst       <= cmd_dst;
                cmd_ready <= 1'b0;
`ifdef ALU_SEQ_REPEAT_EN
                rpt_cnt   <= cmd_rpt;
`endif
            end
            if (state == CAPTURE) begin
                regs[dst] <= alu_c;
                zf        <= alu_zf;
                cf        <= alu_cf;
                if (last) begin
                    done      <= 1'b1;
                    cmd_ready <= 1'b1;
                end
`ifdef ALU_SEQ_REPEAT_EN
                else begin
                    // chain the fresh result into A; B stays as accepted
                    alu_a   <= alu_c;
                    rpt_cnt <= rpt_cnt - 2'd1;
                end
`endif
            end
        end
    end
endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural ALU (op1 = add w/ carry, op2 = AND).
module tb_alu_sequencer;
    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid, cmd_ready, cmd_use_imm;
    logic [3:0] cmd_op, cmd_imm;
    logic [1:0] cmd_dst, cmd_srca, cmd_srcb, cmd_rpt, rd_sel;
    logic [3:0] alu_op, alu_a, alu_b, alu_c, rd_data;
    logic       alu_zf, alu_cf, done, zf, cf;

    int checks   = 0;
    int failures = 0;
    int lat;
    logic [3:0] pre;
    logic       saw_done;

    always #5 clk = ~clk;

    alu_sequencer dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_dst(cmd_dst), .cmd_srca(cmd_srca), .cmd_srcb(cmd_srcb),
        .cmd_use_imm(cmd_use_imm), .cmd_imm(cmd_imm), .cmd_rpt(cmd_rpt),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c),
        .alu_zf(alu_zf), .alu_cf(alu_cf), .done(done), .zf(zf), .cf(cf),
        .rd_sel(rd_sel), .rd_data(rd_data)
    );

    always_comb begin
        alu_c  = 4'h0;
        alu_cf = 1'b0;
        case (alu_op)
            4'h1:    {alu_cf, alu_c} = {1'b0, alu_a} + {1'b0, alu_b};
            4'h2:    alu_c = alu_a & alu_b;
            default: ;
        endcase
        alu_zf = (alu_c == 4'h0);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [3:0] op, input logic [1:0] d, input logic [1:0] sa,
                         input logic [1:0] sb, input logic ie, input logic [3:0] im,
                         input logic [1:0] rp);
        cmd_op = op; cmd_dst = d; cmd_srca = sa; cmd_srcb = sb;
        cmd_use_imm = ie; cmd_imm = im; cmd_rpt = rp;
    endtask

    // Issue one command and count cycles from accept edge until done is seen.
    task automatic run_cmd(input logic [3:0] op, input logic [1:0] d, input logic [1:0] sa,
                           input logic [1:0] sb, input logic ie, input logic [3:0] im,
                           input logic [1:0] rp, output int n, output logic [3:0] pv);
        @(negedge clk);
        drive(op, d, sa, sb, ie, im, rp);
        rd_sel    = d;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        n  = 0;
        pv = 4'h0;
        while (!done && n < 40) begin
            pv = rd_data;
            @(posedge clk); #1;
            n++;
        end
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; rd_sel = 2'd0;
        drive(4'h0, 2'd0, 2'd0, 2'd0, 1'b0, 4'h0, 2'd0);
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rd_sel = 2'(i); #1;
            chk($sformatf("rst_r%0d", i), rd_data, 4'h0);
        end
        chk("rst_zf", zf, 1'b0);
        chk("rst_cf", cf, 1'b0);
        chk("rst_ready", cmd_ready, 1'b1);
        chk("rst_done", done, 1'b0);

        // R0 = 0 + 9
        run_cmd(4'h1, 2'd0, 2'd0, 2'd0, 1'b1, 4'h9, 2'd0, lat, pre);
        chk("ld0_lat", lat, 2);
        chk("ld0_pre", pre, 4'h0);
        chk("ld0_r0", rd_data, 4'h9);
        chk("ld0_zf", zf, 1'b0);
        chk("ld0_cf", cf, 1'b0);

        // R1 = 0 + 9
        run_cmd(4'h1, 2'd1, 2'd1, 2'd0, 1'b1, 4'h9, 2'd0, lat, pre);
        chk("ld1_lat", lat, 2);
        chk("ld1_r1", rd_data, 4'h9);

        // R2 = 9 + 9 -> 2 with carry; done drops 3 cycles after accept
        run_cmd(4'h1, 2'd2, 2'd0, 2'd1, 1'b0, 4'h0, 2'd0, lat, pre);
        chk("ovf_lat", lat, 2);
        chk("ovf_r2", rd_data, 4'h2);
        chk("ovf_cf", cf, 1'b1);
        chk("ovf_zf", zf, 1'b0);
        @(posedge clk); #1;
        chk("ovf_done_end", done, 1'b0);
        chk("ovf_ready", cmd_ready, 1'b1);

        // R3 = 2 & 5 = 0
        run_cmd(4'h2, 2'd3, 2'd2, 2'd0, 1'b1, 4'h5, 2'd0, lat, pre);
        chk("zero_lat", lat, 2);
        chk("zero_r3", rd_data, 4'h0);
        chk("zero_zf", zf, 1'b1);
        chk("zero_cf", cf, 1'b0);

        // back-to-back: R1 = 9+1, then R2 = 2+3 with valid held
        @(negedge clk);
        drive(4'h1, 2'd1, 2'd1, 2'd0, 1'b1, 4'h1, 2'd0);
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        chk("b2b_rdy_t0", cmd_ready, 1'b0);
        drive(4'h1, 2'd2, 2'd2, 2'd0, 1'b1, 4'h3, 2'd0);
        @(posedge clk); #1;
        chk("b2b_rdy_t1", cmd_ready, 1'b0);
        @(posedge clk); #1;
        chk("b2b_rdy_t2", cmd_ready, 1'b1);
        chk("b2b_done_t2", done, 1'b1);
        @(posedge clk); #1;
        chk("b2b_rdy_t3", cmd_ready, 1'b0);
        chk("b2b_done_t3", done, 1'b0);
        cmd_valid = 1'b0;
        lat = 0;
        while (!done && lat < 40) begin @(posedge clk); #1; lat++; end
        chk("b2b_lat2", lat, 2);
        rd_sel = 2'd2; #1;
        chk("b2b_r2", rd_data, 4'h5);
        rd_sel = 2'd1; #1;
        chk("b2b_r1", rd_data, 4'hA);

        // reset during SETTLE of R3 = 9 + 6
        @(negedge clk);
        drive(4'h1, 2'd3, 2'd0, 2'd0, 1'b1, 4'h6, 2'd0);
        rd_sel    = 2'd3;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk("abort_busy", cmd_ready, 1'b0);
        rst = 1'b1; #1;
        chk("abort_async_rdy", cmd_ready, 1'b1);
        @(negedge clk); rst = 1'b0;
        saw_done = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (done) saw_done = 1'b1;
        end
        chk("abort_no_done", saw_done, 1'b0);
        chk("abort_r3", rd_data, 4'h0);
        chk("abort_ready", cmd_ready, 1'b1);

        // repeat: R0 = 1, then R0 + 1 with rpt=3
        run_cmd(4'h1, 2'd0, 2'd0, 2'd0, 1'b1, 4'h1, 2'd0, lat, pre);
        chk("rpt_init_r0", rd_data, 4'h1);
        run_cmd(4'h1, 2'd0, 2'd0, 2'd0, 1'b1, 4'h1, 2'd3, lat, pre);
`ifdef ALU_SEQ_REPEAT_EN
        chk("rpt_lat", lat, 8);
        chk("rpt_r0", rd_data, 4'h5);
`else
        chk("rpt_lat", lat, 2);
        chk("rpt_r0", rd_data, 4'h2);
`endif
        @(posedge clk); #1;
        chk("rpt_done_end", done, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Command-driven controller that sequences the team's 4-bit ALU. It accepts one operation per valid/ready handshake and reads operands from a 4×4-bit register file or an immediate. It drives the ALU opcode and operand inputs from registers, allows two full cycles for the combinational ALU to settle, then writes the result back and latches the zero/carry flags. It sits between the switch/command front end and the ALU instance, and replaces direct switch-to-ALU wiring on the MACH64 demo board.

## Interface
- No parameters. All widths are fixed to the ALU: 4-bit opcode, 4-bit data, 4 registers.
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command
- cmd_op  in  4  ALU opcode, passed through uninterpreted
- cmd_dst  in  2  destination register index
- cmd_srca  in  2  A operand register index
- cmd_srcb  in  2  B operand register index
- cmd_use_imm  in  1  1 = B comes from cmd_imm instead of the register file
- cmd_imm  in  4  immediate B operand
- cmd_rpt  in  2  repeat count; used only when the feature in Configuration is enabled
- alu_op  out  4  registered opcode to the ALU
- alu_a  out  4  registered A operand to the ALU
- alu_b  out  4  registered B operand to the ALU
- alu_c  in  4  ALU result
- alu_zf  in  1  ALU zero flag
- alu_cf  in  1  ALU carry flag
- done  out  1  one-cycle pulse when a command fully completes
- zf  out  1  latched zero flag
- cf  out  1  latched carry flag
- rd_sel  in  2  debug/LED read select
- rd_data  out  4  combinational read of register rd_sel

## Operation
- States: IDLE, SETTLE, CAPTURE.
- IDLE: cmd_ready=1. Register file is read combinationally using cmd_srca/cmd_srcb. On cmd_valid&&cmd_ready:
  - alu_op<=cmd_op; alu_a<=R[srca]; alu_b<=use_imm?imm:R[srcb].
  - dst and rpt are latched.
  - State goes to SETTLE.
- SETTLE: ALU inputs held. Unconditionally goes to CAPTURE.
- CAPTURE: at the closing edge, R[dst]<=alu_c, zf<=alu_zf, cf<=alu_cf.
  - If no repeats remain: done<=1, state goes to IDLE.
- cmd_* inputs are ignored outside IDLE. No command is ever queued.
- srca==dst and srcb==dst are legal. Operands are captured at accept, so there is no hazard.
- rd_data shows the pre-write value during the capture cycle and the new value from the next cycle.
- Reset (any time, including mid-command):
  - State goes to IDLE. R0..R3=0, alu_op/alu_a/alu_b=0, zf=cf=0, done=0.
  - The aborted command produces no writeback and no done.
  - After reset release, cmd_ready=1.
- Widths are exact 4-bit. The sequencer performs no arithmetic on data. Carry comes only from alu_cf.

## Timing
- Accept edge T0. SETTLE runs T0–T1, CAPTURE runs T1–T2. Writeback and flags occur at edge T2.
- done is high T2–T3. cmd_ready is high again from T2.
- A command held valid is accepted at edge T3. Sustained throughput is one command per 3 cycles.
- Latency from the accept edge to the result visible on rd_data is 2 cycles.
- ALU settle budget: alu_* are stable from T0+clk-to-q, and alu_c/zf/cf are sampled at T2, giving 2 clock periods.
- All outputs except rd_data are registered.

## Configuration
- Macro: ALU_SEQ_REPEAT_EN.
- Defined:
  - cmd_rpt=N executes the operation N+1 times.
  - After each non-final CAPTURE: alu_a<=alu_c (the freshly computed result), alu_b is unchanged, state returns to SETTLE, and done is not asserted.
  - Flags and R[dst] update on every iteration. done pulses once, after the final one.
  - Latency is 2(N+1) cycles from accept to writeback.
- Undefined: cmd_rpt is ignored. Every command executes exactly once. The repeat counter logic is not synthesized.

## Test plan
The bench drives alu_c/zf/cf from its own ALU model. In that model, op 4'h1 is a 4-bit add with carry out, and op 4'h2 is A AND B.
- Reset, then rd_sel sweeps 0..3 → rd_data=0 for all registers; zf=cf=0, cmd_ready=1, done=0.
- Load immediates:
  - op 4'h1, R0=R0+imm 4'h9, dst 0 → done at T2+; R0=9, zf=0, cf=0.
  - Then R1=R1+imm 4'h9 → R1=9.
- Overflow: op 4'h1, R0+R1 (9+9), dst 2 → R2=4'h2, cf=1, zf=0. Exactly 3 cycles from accept to the end of done.
- Zero result: op 4'h2, R2 AND imm 4'h5, dst 3 → R3=0, zf=1, cf=0.
- Back-to-back: cmd_valid held for two commands → second accepted exactly 3 cycles after the first. cmd_ready is low for 2 cycles.
- rst asserted during SETTLE of a write to R3=4'hF → R3=0, no done pulse, cmd_ready=1 after release.
- With ALU_SEQ_REPEAT_EN: R0=1, op 4'h1 R0+imm 1, rpt=3, dst 0 → R0=5, a single done pulse 8 cycles after accept. Without the macro, the same command gives R0=2.
